// File: rtl/vol_step_gen.sv
// Front end for the volume register: synchronizes and debounces the encoder and
// button pins, decodes quadrature and button auto-repeat into one-clock step pulses.
module vol_step_gen #(
  parameter int DEB_CYC        = 50_000,
  parameter int TRANS_PER_STEP = 4,
  parameter int RPT_DLY        = 25_000_000,
  parameter int RPT_PER        = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic btn_up_n,
  input  logic btn_dwn_n,
  output logic step_up,
  output logic step_dwn,
  output logic enc_err
);

  localparam int DCW  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int QW   = $clog2(TRANS_PER_STEP + 1) + 1;
  localparam logic signed [QW-1:0] QTOP = QW'(TRANS_PER_STEP);
  localparam logic signed [QW-1:0] QONE = QW'(1);

  // Pin vector: [0]=enc_a [1]=enc_b [2]=btn_up_n [3]=btn_dwn_n
  logic [3:0]           pin;
  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           deb_q, deb_d, prev_q;
  logic [DCW-1:0]       dcnt_q [4];
  logic [DCW-1:0]       dcnt_d [4];
  logic [1:0]           dph;
  logic signed [QW-1:0] q_q, q_d, q_inc, q_dec;
  logic                 enc_up, enc_dwn, enc_bad;
  logic [RCW-1:0]       rcnt_q [2];
  logic [RCW-1:0]       rcnt_d [2];
  logic [1:0]           act_q, act_d, btn_req;
  logic                 both_held;
  logic                 up_req, dwn_req;
  logic                 step_up_q, step_dwn_q, enc_err_q;

  // Position of {A,B} along the clockwise cycle 11 -> 01 -> 00 -> 10.
  function automatic logic [1:0] quad_phase(input logic a, input logic b);
    return {~b, a ^ b};
  endfunction

  assign pin = {btn_dwn_n, btn_up_n, enc_b, enc_a};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DCW'(DEB_CYC - 1)) deb_d[i] = sync2_q[i];
        else                               dcnt_d[i] = dcnt_q[i] + DCW'(1);
      end
    end
  end

  // Phase difference mod 4: 1 = CW, 3 = CCW, 2 = both bits flipped.
  assign dph   = quad_phase(deb_q[0], deb_q[1]) - quad_phase(prev_q[0], prev_q[1]);
  assign q_inc = q_q + QONE;
  assign q_dec = q_q - QONE;

  always_comb begin
    q_d     = q_q;
    enc_up  = 1'b0;
    enc_dwn = 1'b0;
    enc_bad = 1'b0;
    case (dph)
      2'd1: begin
        if (q_inc == QTOP) begin enc_up = 1'b1; q_d = '0; end
        else q_d = q_inc;
      end
      2'd3: begin
        if (q_dec == -QTOP) begin enc_dwn = 1'b1; q_d = '0; end
        else q_d = q_dec;
      end
      2'd2: begin
        enc_bad = 1'b1;
        q_d     = '0;
      end
      default: ;
    endcase
  end

  // A button only arms on its own debounced press edge while the other is released.
  assign both_held = ~deb_q[2] & ~deb_q[3];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      act_d[i]   = act_q[i];
      rcnt_d[i]  = rcnt_q[i];
      btn_req[i] = 1'b0;
      if (deb_q[2+i] || both_held) begin
        act_d[i]  = 1'b0;
        rcnt_d[i] = '0;
      end else if (prev_q[2+i]) begin
        btn_req[i] = 1'b1;
        act_d[i]   = 1'b1;
        rcnt_d[i]  = RCW'(RPT_DLY - 1);
      end else if (act_q[i]) begin
        if (rcnt_q[i] == '0) begin
          btn_req[i] = 1'b1;
          rcnt_d[i]  = RCW'(RPT_PER - 1);
        end else begin
          rcnt_d[i] = rcnt_q[i] - RCW'(1);
        end
      end
    end
  end

  assign up_req  = enc_up  | btn_req[0];
  assign dwn_req = enc_dwn | btn_req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      prev_q     <= '1;
      q_q        <= '0;
      act_q      <= '0;
      step_up_q  <= 1'b0;
      step_dwn_q <= 1'b0;
      enc_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
      for (int i = 0; i < 2; i++) rcnt_q[i] <= '0;
    end else begin
      sync1_q    <= pin;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      prev_q     <= deb_q;
      q_q        <= q_d;
      act_q      <= act_d;
      step_up_q  <= up_req & ~dwn_req;
      step_dwn_q <= dwn_req & ~up_req;
      enc_err_q  <= enc_bad;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
      for (int i = 0; i < 2; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  assign step_up  = step_up_q;
  assign step_dwn = step_dwn_q;
  assign enc_err  = enc_err_q;

endmodule
